// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU unit.
// Restoring shift-subtract divider producing one quotient bit per clock.
// Divide-by-zero and signed overflow are resolved at accept time and skip
// the iteration phase entirely. Results are handed back over a valid/ready
// response handshake. A flush or reset abandons the operation in flight.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      div_op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   state_e            state_q;
   logic              op_rem_q;     // 1: return remainder, 0: return quotient
   logic              q_neg_q;      // quotient must be negated at the end
   logic              r_neg_q;      // remainder must be negated at the end
   logic [XLEN-1:0]   dividend_q;   // magnitude of dividend, shifted out MSB first
   logic [XLEN-1:0]   divisor_q;    // magnitude of divisor
   logic [XLEN-1:0]   rem_q;        // partial remainder
   logic [XLEN-1:0]   quot_q;       // quotient bits collected so far
   logic [CW-1:0]     cnt_q;        // iterations remaining minus one
   logic [XLEN-1:0]   result_q;

   // Accept-time decode signals.
   logic              signed_op;
   logic              is_rem;
   logic [XLEN-1:0]   src1_abs;
   logic [XLEN-1:0]   src2_abs;
   logic              div_zero;
   logic              overflow;
   logic              special;
   logic [XLEN-1:0]   special_res;

   // One iteration of the restoring divider plus final sign fix-up.
   logic [XLEN:0]     rem_shift;
   logic [XLEN:0]     rem_diff;
   logic              q_bit;
   logic [XLEN-1:0]   rem_d;
   logic [XLEN-1:0]   quot_d;
   logic [XLEN-1:0]   final_res;

   // Decode the incoming request: operand magnitudes and the short-cut cases.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      signed_op   = ~div_op[0];
      is_rem      = div_op[1];
      src1_abs    = (signed_op && src1[XLEN-1]) ? -src1 : src1;
      src2_abs    = (signed_op && src2[XLEN-1]) ? -src2 : src2;
      div_zero    = (src2 == '0);
      overflow    = signed_op && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
      special     = div_zero || overflow;
      special_res = '0;
      if (div_zero) begin
         special_res = is_rem ? src1 : '1;
      end else if (overflow) begin
         special_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
   end

   // Shift-subtract step; the XLEN+1-bit compare keeps the bit shifted out of rem_q.
   always_comb begin
      rem_shift = {rem_q, dividend_q[XLEN-1]};
      rem_diff  = rem_shift - {1'b0, divisor_q};
      // rem_q < divisor holds, so a non-negative difference always fits in XLEN
      // bits and the top bit of rem_diff is a clean borrow flag.
      q_bit     = ~rem_diff[XLEN];
      rem_d     = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      quot_d    = {quot_q[XLEN-2:0], q_bit};
      final_res = op_rem_q ? (r_neg_q ? -rem_d  : rem_d)
                           : (q_neg_q ? -quot_d : quot_d);
   end

   // Control FSM and datapath registers; flush overrides accept and handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // register samples values from before the edge.
         state_q    <= IDLE;
         op_rem_q   <= 1'b0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
      end else if (flush) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  op_rem_q   <= is_rem;
                  q_neg_q    <= signed_op && (src1[XLEN-1] ^ src2[XLEN-1]);
                  r_neg_q    <= signed_op && src1[XLEN-1];
                  dividend_q <= src1_abs;
                  divisor_q  <= src2_abs;
                  rem_q      <= '0;
                  quot_q     <= '0;
                  cnt_q      <= CW'(XLEN - 1);
                  if (special) begin
                     result_q <= special_res;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= CALC;
                  end
               end
            end
            CALC: begin
               dividend_q <= dividend_q << 1;
               rem_q      <= rem_d;
               quot_q     <= quot_d;
               cnt_q      <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  result_q <= final_res;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign result     = result_q;

endmodule
